// File: rtl/myproject_mul_share_arb.sv
// Purpose : round-robin time-sharing of one external 16s x 12u multiplier among NREQ requesters.
// Latency : 1 cycle from grant (req_ready) to registered, ID-tagged response.
// Backpr. : no grant while the response register is full and rsp_ready is low; response held stable.
// Option  : define MUL_ARB_STATS_EN to add per-requester saturating 16-bit grant counters.
module myproject_mul_share_arb #(
   parameter int NREQ   = 4,
   parameter int DIN0_W = 16,
   parameter int DIN1_W = 12,
   parameter int DOUT_W = DIN0_W + DIN1_W,
   parameter int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*DIN0_W-1:0]   req_a,
   input  logic [NREQ*DIN1_W-1:0]   req_b,
   output logic [DIN0_W-1:0]        mul_din0,
   output logic [DIN1_W-1:0]        mul_din1,
   input  logic [DOUT_W-1:0]        mul_dout,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [DOUT_W-1:0]        rsp_data
`ifdef MUL_ARB_STATS_EN
   ,
   output logic [NREQ*16-1:0]       stat_grant_cnt
`endif
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [DOUT_W-1:0] rsp_data_q, rsp_data_d;

   logic              can_issue;
   logic              gnt_vld;
   logic [ID_W-1:0]   gnt_idx;
   logic [NREQ-1:0]   gnt_oh;
   logic [ID_W-1:0]   cand;
   int                idx;

   // Round-robin search: walk from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin
      gnt_vld   = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      idx       = 0;
      can_issue = (state_q == S_EMPTY) || rsp_ready;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         cand = ID_W'(idx);
         if (req_valid[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
      // Nothing is granted while in reset or while the response slot cannot be refilled.
      gnt_vld = gnt_vld && can_issue && ap_rst_n;
   end

   // One-hot grant drives req_ready and steers the granted operands onto the shared multiplier.
   always_comb begin
      gnt_oh   = '0;
      mul_din0 = '0;
      mul_din1 = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_vld && (gnt_idx == ID_W'(i))) begin
            gnt_oh[i] = 1'b1;
            mul_din0  = req_a[i*DIN0_W +: DIN0_W];
            mul_din1  = req_b[i*DIN1_W +: DIN1_W];
         end
      end
   end

   assign req_ready = gnt_oh;

   // Response register next state: load on grant, drain when consumed, otherwise hold.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      if (gnt_vld) begin
         state_d    = S_FULL;
         rsp_id_d   = gnt_idx;
         rsp_data_d = mul_dout;
         if (int'(gnt_idx) == NREQ - 1) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = gnt_idx + ID_W'(1);
         end
      end else if (rsp_ready) begin
         state_d = S_EMPTY;
      end
   end

   // State registers; reset discards any held response.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q    <= S_EMPTY;
         rr_ptr_q   <= '0;
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign rsp_valid = (state_q == S_FULL);
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

`ifdef MUL_ARB_STATS_EN
   logic [15:0] cnt_q [NREQ];
   logic [15:0] cnt_d [NREQ];

   // Per-requester grant counters, saturating at all-ones.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         cnt_d[i] = cnt_q[i];
         if (gnt_oh[i] && (cnt_q[i] != 16'hFFFF)) begin
            cnt_d[i] = cnt_q[i] + 16'd1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < NREQ; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Flatten counters onto the stats port, requester i in slice [i*16 +: 16].
   always_comb begin
      stat_grant_cnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         stat_grant_cnt[i*16 +: 16] = cnt_q[i];
      end
   end
`endif

endmodule
